// File: rtl/ram_if_pkg.sv
// ram_if_pkg
//   Constants and width helpers shared by the byte-enabled single-port RAM
//   and every initiator that drives it.
//   - DEFAULT_DATA_WIDTH / DEFAULT_RAM_DEPTH : default RAM geometry
//   - wren_width(data_width)                 : one write enable per byte lane
//   - addr_width(ram_depth)                  : word address width
package ram_if_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_RAM_DEPTH  = 512;

    function automatic int wren_width(input int data_width);
        return (data_width + 7) / 8;
    endfunction

    // A one-word RAM still needs a one-bit address port.
    function automatic int addr_width(input int ram_depth);
        return (ram_depth > 1) ? $clog2(ram_depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with occupancy count and registered storage.
//   DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset (clears pointers, count, storage)
//   push_i       write push_data_i at the tail (ignored when full without pop)
//   push_data_i  data to enqueue
//   pop_i        remove the head entry (ignored when empty)
//   pop_data_o   head entry, valid whenever empty_o is low
//   empty_o      no entries
//   count_o      number of entries, 0..DEPTH
module sync_fifo #(
    parameter  int WIDTH     = 32,
    parameter  int DEPTH     = 4,
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     push_data_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     pop_data_o,
    output logic                 empty_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 do_push;
    logic                 do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // When full, a simultaneous pop frees the head slot in the same edge; the
    // write lands in that slot after the head has already been read out.
    assign do_push = push_i && ((count_q != FULL_COUNT) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is reset so the head output reads 0 while the FIFO is empty
    // after reset instead of an undefined value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/ram_initiator.sv
// ram_initiator
//   Turns a valid/ready command stream (read or byte-masked write) into
//   single-cycle pulses on the byte-enabled single-port RAM and returns read
//   data, in issue order, through a response FIFO with valid/ready.
//   A command is only accepted while FIFO occupancy plus reads in flight is
//   below RSP_DEPTH, so every read acknowledge has a free FIFO slot.
// Ports:
//   clkIn / rstnIn        clock, asynchronous active-low reset
//   cmdValidIn/ReadyOut   command handshake
//   cmdRdIn               1 = read, 0 = write
//   cmdAddrIn             word address
//   cmdWrEnIn/WrDataIn    byte enables and write data (writes only)
//   rspValidOut/ReadyIn   read response handshake
//   rspDataOut            read data, held while stalled
//   ramAddrOut/WrEnOut/WrDataOut/RdEnOut   registered RAM drive
//   ramRdDataIn/RdAckIn   RAM read return, ack one cycle after rdEn
//   errOut                sticky: read ack seen with no read in flight
module ram_initiator
    import ram_if_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int RAM_DEPTH  = DEFAULT_RAM_DEPTH,
    parameter  int RSP_DEPTH  = 4,
    localparam int ADDR_WIDTH = addr_width(RAM_DEPTH),
    localparam int WREN_WIDTH = wren_width(DATA_WIDTH)
) (
    input  logic                  clkIn,
    input  logic                  rstnIn,
    input  logic                  cmdValidIn,
    output logic                  cmdReadyOut,
    input  logic                  cmdRdIn,
    input  logic [ADDR_WIDTH-1:0] cmdAddrIn,
    input  logic [WREN_WIDTH-1:0] cmdWrEnIn,
    input  logic [DATA_WIDTH-1:0] cmdWrDataIn,
    output logic                  rspValidOut,
    input  logic                  rspReadyIn,
    output logic [DATA_WIDTH-1:0] rspDataOut,
    output logic [ADDR_WIDTH-1:0] ramAddrOut,
    output logic [WREN_WIDTH-1:0] ramWrEnOut,
    output logic [DATA_WIDTH-1:0] ramWrDataOut,
    output logic                  ramRdEnOut,
    input  logic [DATA_WIDTH-1:0] ramRdDataIn,
    input  logic                  ramRdAckIn,
    output logic                  errOut
);

    localparam int                   CNT_WIDTH    = $clog2(RSP_DEPTH) + 1;
    localparam logic [CNT_WIDTH:0]   CREDIT_LIMIT = (CNT_WIDTH + 1)'(RSP_DEPTH);

    logic [CNT_WIDTH-1:0]  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [WREN_WIDTH-1:0] ram_wren_q, ram_wren_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  ram_rden_q, ram_rden_d;
    logic                  err_q, err_d;

    logic [CNT_WIDTH-1:0]  fifo_count;
    logic                  fifo_empty;
    logic [CNT_WIDTH:0]    credits_used;
    logic                  accept;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  ack_expected;
    logic                  ack_spurious;
    logic                  rsp_pop;

    // Credits cover both the FIFO and the reads still on their way back.
    assign credits_used = {1'b0, fifo_count} + {1'b0, inflight_q};
    // Gating with rstnIn keeps ready low for the whole reset assertion.
    assign cmdReadyOut  = rstnIn && (credits_used < CREDIT_LIMIT);

    assign accept       = cmdValidIn && cmdReadyOut;
    assign rd_accept    = accept && cmdRdIn;
    assign wr_accept    = accept && !cmdRdIn;
    assign ack_expected = ramRdAckIn && (inflight_q != '0);
    assign ack_spurious = ramRdAckIn && (inflight_q == '0);

    always_comb begin
        inflight_d = inflight_q;
        case ({rd_accept, ack_expected})
            2'b10:   inflight_d = inflight_q + CNT_WIDTH'(1);
            2'b01:   inflight_d = inflight_q - CNT_WIDTH'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Address and write data hold between commands; the strobes are
    // single-cycle pulses.
    always_comb begin
        ram_addr_d  = accept    ? cmdAddrIn   : ram_addr_q;
        ram_wdata_d = wr_accept ? cmdWrDataIn : ram_wdata_q;
        ram_wren_d  = wr_accept ? cmdWrEnIn   : '0;
        ram_rden_d  = rd_accept;
        err_d       = err_q || ack_spurious;
    end

    always_ff @(posedge clkIn or negedge rstnIn) begin
        if (!rstnIn) begin
            inflight_q  <= '0;
            ram_addr_q  <= '0;
            ram_wren_q  <= '0;
            ram_wdata_q <= '0;
            ram_rden_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            ram_addr_q  <= ram_addr_d;
            ram_wren_q  <= ram_wren_d;
            ram_wdata_q <= ram_wdata_d;
            ram_rden_q  <= ram_rden_d;
            err_q       <= err_d;
        end
    end

    assign ramAddrOut   = ram_addr_q;
    assign ramWrEnOut   = ram_wren_q;
    assign ramWrDataOut = ram_wdata_q;
    assign ramRdEnOut   = ram_rden_q;
    assign errOut       = err_q;

    assign rspValidOut  = !fifo_empty;
    assign rsp_pop      = rspValidOut && rspReadyIn;

    // A spurious ack is never pushed: its data is discarded.
    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (clkIn),
        .rst_n_i     (rstnIn),
        .push_i      (ack_expected),
        .push_data_i (ramRdDataIn),
        .pop_i       (rsp_pop),
        .pop_data_o  (rspDataOut),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_ram_initiator.sv
module tb_ram_initiator;

    localparam int DW    = 32;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int WW    = 4;
    localparam int RD    = 4;

    logic          clkIn = 1'b0;
    logic          rstnIn;
    logic          cmdValidIn;
    logic          cmdReadyOut;
    logic          cmdRdIn;
    logic [AW-1:0] cmdAddrIn;
    logic [WW-1:0] cmdWrEnIn;
    logic [DW-1:0] cmdWrDataIn;
    logic          rspValidOut;
    logic          rspReadyIn;
    logic [DW-1:0] rspDataOut;
    logic [AW-1:0] ramAddrOut;
    logic [WW-1:0] ramWrEnOut;
    logic [DW-1:0] ramWrDataOut;
    logic          ramRdEnOut;
    logic [DW-1:0] ramRdDataIn;
    logic          ramRdAckIn;
    logic          errOut;

    always #5 clkIn = ~clkIn;

    ram_initiator #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .RSP_DEPTH(RD)) dut (
        .clkIn        (clkIn),
        .rstnIn       (rstnIn),
        .cmdValidIn   (cmdValidIn),
        .cmdReadyOut  (cmdReadyOut),
        .cmdRdIn      (cmdRdIn),
        .cmdAddrIn    (cmdAddrIn),
        .cmdWrEnIn    (cmdWrEnIn),
        .cmdWrDataIn  (cmdWrDataIn),
        .rspValidOut  (rspValidOut),
        .rspReadyIn   (rspReadyIn),
        .rspDataOut   (rspDataOut),
        .ramAddrOut   (ramAddrOut),
        .ramWrEnOut   (ramWrEnOut),
        .ramWrDataOut (ramWrDataOut),
        .ramRdEnOut   (ramRdEnOut),
        .ramRdDataIn  (ramRdDataIn),
        .ramRdAckIn   (ramRdAckIn),
        .errOut       (errOut)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] seed;
    bit  spur_ack = 1'b0;
    bit  rnd_rdy  = 1'b0;
    bit  err_exp  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return seed ^ (32'(i) * 32'h9E37_79B9) ^ {16'(i), 16'h5A5A};
    endfunction

    always @(posedge clkIn) cyc <= cyc + 1;

    // RAM model: one-cycle read with ack, byte-masked write, read-before-write.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_rdata_q = '0;
    logic          ram_ack_q;
    bit            ram_loaded = 1'b0;

    always @(posedge clkIn) begin
        if (!ram_loaded) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= pat(i);
            ram_loaded <= 1'b1;
        end else begin
            if (ramRdEnOut) ram_rdata_q <= ram_mem[ramAddrOut];
            for (int b = 0; b < WW; b++)
                if (ramWrEnOut[b]) ram_mem[ramAddrOut][b*8 +: 8] <= ramWrDataOut[b*8 +: 8];
        end
    end

    always @(posedge clkIn or negedge rstnIn) begin
        if (!rstnIn) ram_ack_q <= 1'b0;
        else         ram_ack_q <= ramRdEnOut;
    end

    assign ramRdAckIn  = ram_ack_q | spur_ack;
    assign ramRdDataIn = ram_rdata_q;

    // Reference model: a word array updated at command acceptance plus an
    // ordered queue of expected read data. Everything accepted and not yet
    // popped holds a credit.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_loaded = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rsp_data_q[$];
    int            rsp_cyc_q[$];
    bit            p_valid = 1'b0;
    bit            p_rd    = 1'b0;
    logic [WW-1:0] p_wren  = '0;
    logic [AW-1:0] p_addr  = '0;
    logic [DW-1:0] p_wdata = '0;

    always @(negedge clkIn) begin
        if (!ref_loaded) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
            ref_loaded = 1'b1;
        end
        if (!rstnIn) begin
            exp_q.delete();
            p_valid = 1'b0; p_rd = 1'b0; p_wren = '0;
        end else begin
            check("ram_rden", ramRdEnOut, p_valid && p_rd);
            check("ram_wren", ramWrEnOut, (p_valid && !p_rd) ? p_wren : '0);
            if (p_valid) check("ram_addr", ramAddrOut, p_addr);
            if (p_valid && !p_rd) check("ram_wdata", ramWrDataOut, p_wdata);
            check("cmd_ready", cmdReadyOut, exp_q.size() < RD);
            check("err", errOut, err_exp);
            if (exp_q.size() == 0) check("rsp_valid_idle", rspValidOut, 1'b0);
            if (rspValidOut && rspReadyIn && exp_q.size() != 0) begin
                check("rsp_data", rspDataOut, exp_q[0]);
                void'(exp_q.pop_front());
                rsp_data_q.push_back(rspDataOut);
                rsp_cyc_q.push_back(cyc);
            end
            p_valid = cmdValidIn && cmdReadyOut;
            p_rd    = cmdRdIn;
            p_wren  = cmdWrEnIn;
            p_addr  = cmdAddrIn;
            p_wdata = cmdWrDataIn;
            if (p_valid) begin
                if (p_rd) exp_q.push_back(ref_mem[p_addr]);
                else
                    for (int b = 0; b < WW; b++)
                        if (p_wren[b]) ref_mem[p_addr][b*8 +: 8] = p_wdata[b*8 +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    // Present a command and hold it until accepted; leaves cmdValidIn high.
    task automatic issue(input bit rd, input int addr, input logic [WW-1:0] wren,
                         input logic [DW-1:0] data, output int acc_cyc, output int waits);
        bit acc;
        cmdValidIn  = 1'b1;
        cmdRdIn     = rd;
        cmdAddrIn   = AW'(addr);
        cmdWrEnIn   = wren;
        cmdWrDataIn = data;
        acc = 1'b0; waits = 0; acc_cyc = 0;
        while (!acc && waits < 100) begin
            @(negedge clkIn);
            acc = cmdReadyOut;
            acc_cyc = cyc;
            tick();
            if (rnd_rdy) rspReadyIn = ($urandom_range(0, 3) != 0);
            waits++;
        end
        check("issue_accept", acc, 1'b1);
    endtask

    task automatic idle();
        cmdValidIn = 1'b0;
        cmdWrEnIn  = '0;
    endtask

    task automatic wait_rsp(input int target);
        int k = 0;
        while (rsp_data_q.size() < target && k < 100) begin
            tick();
            k++;
        end
        check("rsp_wait", rsp_data_q.size() >= target, 1'b1);
    endtask

    task automatic drain();
        int k = 0;
        rspReadyIn = 1'b1;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ac, ac0, w, n0;
        seed        = $urandom;
        rstnIn      = 1'b0;
        cmdValidIn  = 1'b1;
        cmdRdIn     = 1'b1;
        cmdAddrIn   = '0;
        cmdWrEnIn   = '1;
        cmdWrDataIn = '1;
        rspReadyIn  = 1'b1;

        // Reset with a command presented
        repeat (3) begin
            @(negedge clkIn);
            check("rst_ready", cmdReadyOut, 1'b0);
            check("rst_rsp_valid", rspValidOut, 1'b0);
            check("rst_rsp_data", rspDataOut, '0);
            check("rst_ram_addr", ramAddrOut, '0);
            check("rst_ram_wren", ramWrEnOut, '0);
            check("rst_ram_wdata", ramWrDataOut, '0);
            check("rst_ram_rden", ramRdEnOut, 1'b0);
            check("rst_err", errOut, 1'b0);
        end
        tick();
        idle();
        rstnIn = 1'b1;
        tick();

        // Full-word write then read
        issue(1'b0, 5, 4'hF, 32'hDEADBEEF, ac, w);
        n0 = rsp_data_q.size();
        issue(1'b1, 5, 4'h0, 32'h0, ac, w);
        idle();
        wait_rsp(n0 + 1);
        check("t2_data", rsp_data_q[n0], 32'hDEADBEEF);
        check("t2_latency", rsp_cyc_q[n0] - ac, 3);

        // Byte write then read
        issue(1'b0, 5, 4'b0010, 32'h0000AA00, ac, w);
        n0 = rsp_data_q.size();
        issue(1'b1, 5, 4'h0, 32'h0, ac, w);
        idle();
        wait_rsp(n0 + 1);
        check("t3_data", rsp_data_q[n0], 32'hDEADAAEF);

        // Backpressure: only RD reads accepted while responses are stalled
        rspReadyIn = 1'b0;
        n0 = rsp_data_q.size();
        for (int a = 0; a < 4; a++) begin
            issue(1'b1, a, 4'h0, 32'h0, ac, w);
            check("t4_no_stall", w, 1);
        end
        cmdRdIn   = 1'b1;
        cmdAddrIn = AW'(4);
        repeat (3) begin
            @(negedge clkIn);
            check("t4_blocked", cmdReadyOut, 1'b0);
            tick();
        end
        rspReadyIn = 1'b1;
        issue(1'b1, 4, 4'h0, 32'h0, ac, w);
        issue(1'b1, 5, 4'h0, 32'h0, ac, w);
        idle();
        drain();
        repeat (3) tick();
        check("t4_rsp_count", rsp_data_q.size() - n0, 6);

        // Throughput: 8 back-to-back reads
        rspReadyIn = 1'b1;
        n0 = rsp_data_q.size();
        ac0 = 0;
        for (int a = 0; a < 8; a++) begin
            issue(1'b1, a, 4'h0, 32'h0, ac, w);
            if (a == 0) ac0 = ac;
            check("t5_no_stall", w, 1);
        end
        idle();
        wait_rsp(n0 + 8);
        for (int k = 0; k < 8; k++)
            check("t5_rsp_cycle", rsp_cyc_q[n0 + k] - ac0, 3 + k);

        // Random mix with random response backpressure and hazards
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  WW'($urandom), $urandom, ac, w);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                tick();
                rspReadyIn = ($urandom_range(0, 1) != 0);
            end
        end
        rnd_rdy = 1'b0;
        idle();
        drain();
        repeat (3) tick();

        // Spurious ack with three responses parked in the FIFO
        rspReadyIn = 1'b0;
        n0 = rsp_data_q.size();
        for (int a = 20; a < 23; a++) issue(1'b1, a, 4'h0, 32'h0, ac, w);
        idle();
        repeat (4) tick();
        spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        err_exp  = 1'b1;
        repeat (2) tick();
        check("t6_err_set", errOut, 1'b1);
        check("t6_ready", cmdReadyOut, 1'b1);
        drain();
        repeat (4) tick();
        check("t6_rsp_count", rsp_data_q.size() - n0, 3);
        check("t6_err_held", errOut, 1'b1);
        rstnIn  = 1'b0;
        err_exp = 1'b0;
        @(negedge clkIn);
        check("t6_err_cleared", errOut, 1'b0);
        check("t6_rst_ready", cmdReadyOut, 1'b0);
        tick();
        rstnIn = 1'b1;
        repeat (2) tick();
        check("t6_err_after_rst", errOut, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_initiator.md
Name: ram_initiator

Overview:
- Initiator/master for the team's single-port byte-enabled RAM.
- Converts a valid/ready command stream (read or byte-masked write) into single-cycle RAM port pulses.
- Collects read data returned with the RAM's read-acknowledge into a response FIFO with valid/ready backpressure.
- Sits between accelerator datapath engines and the RAM instance; guarantees no read response is ever dropped.

Parameters:
- DATA_WIDTH, 32, data width of commands, RAM and responses.
- RAM_DEPTH, 512, RAM words; ADDR_WIDTH = $clog2(RAM_DEPTH).
- RSP_DEPTH, 4, response FIFO entries, power of two, at least 2; also the read credit limit.
- Derived: WREN_WIDTH = (DATA_WIDTH+7)/8.

Ports:
- clkIn  in  1  clock; single clock domain, all logic rising-edge.
- rstnIn  in  1  reset, asynchronous, active-low.
- cmdValidIn  in  1  command valid.
- cmdReadyOut  out  1  command ready.
- cmdRdIn  in  1  1 = read, 0 = write.
- cmdAddrIn  in  ADDR_WIDTH  word address.
- cmdWrEnIn  in  WREN_WIDTH  byte write enables; ignored for reads.
- cmdWrDataIn  in  DATA_WIDTH  write data.
- rspValidOut  out  1  read response valid.
- rspReadyIn  in  1  response consumer ready.
- rspDataOut  out  DATA_WIDTH  read data.
- ramAddrOut  out  ADDR_WIDTH  to RAM address.
- ramWrEnOut  out  WREN_WIDTH  to RAM byte write enables.
- ramWrDataOut  out  DATA_WIDTH  to RAM write data.
- ramRdEnOut  out  1  to RAM read enable.
- ramRdDataIn  in  DATA_WIDTH  from RAM read data.
- ramRdAckIn  in  1  from RAM read acknowledge; one cycle after the ramRdEnOut cycle.
- errOut  out  1  sticky protocol error.

Behaviour:
- Reset values: cmdReadyOut=0 while rstnIn low; all other outputs 0; FIFO empty; in-flight counter 0. The RAM's active-high reset is driven from the inverted rstnIn at top level.
- Accept: a command is accepted at any rising edge where cmdValidIn && cmdReadyOut.
- Ready: cmdReadyOut = (fifoCount + inflight < RSP_DEPTH), registered-free combinational from state only; it does not depend on cmdValidIn or cmdRdIn. It applies to writes too.
- RAM drive: all RAM outputs are registered.
  - In the cycle after an accept (N+1), ramAddrOut = cmd address.
  - For a read: ramRdEnOut=1, ramWrEnOut=0.
  - For a write: ramWrEnOut=cmdWrEnIn, ramRdEnOut=0, ramWrDataOut=data.
  - In non-accept cycles ramWrEnOut=0 and ramRdEnOut=0; address and data hold their last value.
- Degenerate commands: a write with cmdWrEnIn==0 is accepted and has no effect. Throughput is one command per cycle.
- Read latency: accept at edge N -> rdEn cycle N+1 -> ramRdAckIn cycle N+2 -> pushed to FIFO at end of N+2 -> rspValidOut high in cycle N+3. This is 3 cycles when the FIFO is empty and rspReadyIn=1.
- In-flight counter: width $clog2(RSP_DEPTH)+1.
  - +1 on read accept, -1 on ramRdAckIn; simultaneous events give a net change.
  - Credits count FIFO occupancy plus in-flight reads, so a FIFO push can never overflow.
- Ordering: responses are strictly in issue order. Write-then-read to the same address returns the new data; read-then-write returns the old data, per RAM read-before-write.
- Response FIFO: push on ramRdAckIn, pop on rspValidOut && rspReadyIn.
  - Push and pop in the same cycle keep the count unchanged, including when the FIFO is full.
  - Pointers wrap modulo RSP_DEPTH.
  - rspDataOut is stable while rspValidOut=1 and rspReadyIn=0.
- Error: ramRdAckIn while inflight==0 (for example a stale ack after mid-operation reset) sets errOut=1. The data is discarded, counters are unchanged, and errOut stays set until reset.
- Mid-operation reset: all state clears immediately. Outstanding reads are abandoned.

Decomposition:
- Shared package ram_if_pkg: WREN_WIDTH/ADDR_WIDTH derivation functions and the default DATA_WIDTH/RAM_DEPTH constants, shared with the RAM and other initiators.
- One sub-module: sync_fifo. It is a parameterised width/depth synchronous FIFO with count, async active-low reset, and registered storage, instantiated as the response FIFO.
- The top module holds the command register, in-flight counter, credit logic and error flag.

Test Plan:
1. Reset: hold rstnIn=0 for 3 cycles with cmdValidIn=1 -> no accept; every output 0; errOut=0.
2. Full-word write then read: write addr 5, wrEn 4'hF, data 32'hDEADBEEF; then read addr 5 -> rspValidOut high 3 cycles after the read accept with rspDataOut=32'hDEADBEEF.
3. Byte write: write addr 5, wrEn 4'b0010, data 32'h0000AA00; then read addr 5 -> 32'hDEADAAEF.
4. Backpressure: RSP_DEPTH=4, rspReadyIn=0, 6 back-to-back reads of addr 0..5 -> exactly 4 accepted, then cmdReadyOut=0. Raise rspReadyIn -> all 6 responses in address order, no loss or duplication.
5. Throughput: rspReadyIn=1, reads of addr 0..7 on consecutive cycles -> cmdReadyOut stays 1 and 8 consecutive responses start 3 cycles after the first accept.
6. Spurious ack: force ramRdAckIn=1 with no read outstanding -> errOut=1, FIFO count unchanged, errOut held until rstnIn asserted.
